avalon_st_pkt_fifo: RTL and testbench
=====================================

Name: avalon_st_pkt_fifo

Overview:
Parametrised Avalon-ST packet FIFO placed between an Avalon-ST source and sink in the packet-copy datapath. It carries data, channel, error, startofpacket, endofpacket and empty on both sides, all with ready latency 0. It has two modes:
- Cut-through (STORE_FWD=0): beats are forwarded as soon as they are stored.
- Store-and-forward (STORE_FWD=1): a packet is released only after its EOP is accepted. Errored, oversize and malformed packets are dropped and counted.

Parameters:
BITS_PER_SYMBOL  8  bits per symbol
SYMBOLS_PER_BEAT  4  symbols per beat; DATA_W = BITS_PER_SYMBOL*SYMBOLS_PER_BEAT
CHANNEL_W  2  channel width (1..5)
ERROR_W  1  error width (1..8)
DEPTH  64  beats of storage; power of two, >=4
STORE_FWD  1  1 = store-and-forward, 0 = cut-through
DROP_ON_ERROR  1  store-and-forward only: discard a packet whose EOP beat has error!=0
(derived) EMPTY_W = max(1, clog2(SYMBOLS_PER_BEAT)); PTR_W = clog2(DEPTH)

Ports:
clk  in  1  clock; all logic on rising edge
resetn  in  1  synchronous reset, active-low
snk_valid  in  1  input beat valid
snk_ready  out  1  FIFO can accept a beat this cycle
snk_data  in  DATA_W  input data
snk_channel  in  CHANNEL_W  input channel
snk_error  in  ERROR_W  input error
snk_startofpacket  in  1  input SOP
snk_endofpacket  in  1  input EOP
snk_empty  in  EMPTY_W  empty symbols on EOP beat
src_valid  out  1  output beat valid
src_ready  in  1  downstream ready
src_data  out  DATA_W  output data
src_channel  out  CHANNEL_W  output channel
src_error  out  ERROR_W  output error
src_startofpacket  out  1  output SOP
src_endofpacket  out  1  output EOP
src_empty  out  EMPTY_W  output empty
fill_level  out  PTR_W+1  beats written but not yet read (includes uncommitted beats)
drop_count  out  16  dropped packets; saturates at 16'hFFFF

Behaviour:
- Reset (resetn=0 at a clock edge):
  - pointers wr_ptr, commit_ptr and rd_ptr all go to 0; state goes to IDLE.
  - outputs: src_valid=0, snk_ready=0 during reset and 1 on the first cycle after; fill_level=0; drop_count=0.
  - A packet in flight at reset is lost and not counted.
- Handshakes: a beat is accepted when snk_valid&snk_ready; a beat is consumed when src_valid&src_ready.
  - src_* outputs are held stable while src_valid=1 and src_ready=0.
- Storage: a simple dual-port RAM, one entry per beat: {data, channel, error, sop, eop, empty}. The RAM has a synchronous read feeding a one-entry output register (skid/prefetch).
- Full: wr_ptr - rd_ptr == DEPTH, evaluated on pre-edge state. A read in the same cycle does not free space for a write in that cycle.
- snk_ready: 1 in state DROP; otherwise !full.
- Readable region is rd_ptr..commit_ptr-1.
  - Cut-through: commit_ptr follows wr_ptr on every accepted beat.
  - Store-and-forward: on an accepted EOP beat without drop, commit_ptr <= wr_ptr+1.
- Latency:
  - A committed beat reaches src_valid=1 two edges after commit (edge T accepts/commits; src_valid visible after edge T+2).
  - Back-to-back throughput is 1 beat/cycle.
- State machine (ingress; store-and-forward mode only, cut-through stays in IDLE/PKT):
  - IDLE: an accepted beat with SOP is written, go to PKT (SOP+EOP single-beat packet commits and stays IDLE). An accepted beat without SOP is discarded and not counted.
  - PKT: each accepted beat is written.
    - EOP with error!=0 and DROP_ON_ERROR=1: wr_ptr <= commit_ptr, drop_count+1, go to IDLE.
    - EOP otherwise: commit, go to IDLE.
    - SOP arriving (missing EOP): rewind wr_ptr to commit_ptr, drop_count+1, write this beat as the start of a new packet, stay in PKT.
    - If full and commit_ptr==rd_ptr (packet cannot fit): rewind wr_ptr to commit_ptr, drop_count+1, go to DROP.
  - DROP: accept and discard all beats. EOP goes to IDLE. SOP rewinds wr_ptr, starts a new packet, goes to PKT (no further count).
- Cut-through mode: never drops; error, missing EOP and stray beats pass through unchanged.
- Pointer arithmetic uses PTR_W+1 bits with natural wrap; the RAM index is the low PTR_W bits.

Decomposition:
- Package avalon_st_pkg: ingress state enum (IDLE, PKT, DROP), localparam DROP_CNT_W=16, and function empty_w(symbols) returning max(1,clog2).
- Sub-module avalon_st_sdp_ram: parametrised simple dual-port RAM with synchronous read (WIDTH, DEPTH).

Test Plan:
- Cut-through, 3-beat packet, src_ready=1: data A,B,C accepted at edges 0..2 → src_valid from after edge 2, beats A,B,C with SOP on A, EOP+empty on C.
- Store-and-forward, 5-beat packet, src_ready=1 → src_valid stays 0 until 2 edges after the EOP edge; then 5 consecutive beats; fill_level peaks at 5.
- Store-and-forward, DROP_ON_ERROR=1, 4-beat packet with error=1 on EOP, then a clean 2-beat packet → only the 2-beat packet appears at output; drop_count=1.
- DEPTH=8, 12-beat packet with src_ready=0 → snk_ready never deasserts for more than 1 cycle; packet dropped; drop_count=1; fill_level=0; a following 3-beat packet passes.
- SOP, beat, then SOP again (missing EOP), beat, EOP → only the second 3-beat packet is output; drop_count=1.
- src_ready toggling 1010…, resetn pulsed low mid-packet → outputs hold while stalled; after reset src_valid=0, fill_level=0, drop_count=0, snk_ready=1 the next cycle.

Source files
------------

// File: rtl/avalon_st_pkg.sv
// Shared types and helpers for the Avalon-ST packet FIFO.
package avalon_st_pkg;

  typedef enum logic [1:0] {IDLE, PKT, DROP} ingress_state_t;

  localparam int DROP_CNT_W = 16;

  function automatic int empty_w(input int symbols);
    return (symbols > 2) ? $clog2(symbols) : 1;
  endfunction

endpackage

// File: rtl/avalon_st_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module avalon_st_sdp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/avalon_st_pkt_fifo.sv
// Avalon-ST packet FIFO with cut-through or store-and-forward release and
// packet dropping (error, oversize, malformed) in store-and-forward mode.
module avalon_st_pkt_fifo
  import avalon_st_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 4,
  parameter int CHANNEL_W        = 2,
  parameter int ERROR_W          = 1,
  parameter int DEPTH            = 64,
  parameter bit STORE_FWD        = 1'b1,
  parameter bit DROP_ON_ERROR    = 1'b1,
  localparam int DATA_W  = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  localparam int EMPTY_W = empty_w(SYMBOLS_PER_BEAT),
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  snk_valid,
  output logic                  snk_ready,
  input  logic [DATA_W-1:0]     snk_data,
  input  logic [CHANNEL_W-1:0]  snk_channel,
  input  logic [ERROR_W-1:0]    snk_error,
  input  logic                  snk_startofpacket,
  input  logic                  snk_endofpacket,
  input  logic [EMPTY_W-1:0]    snk_empty,
  output logic                  src_valid,
  input  logic                  src_ready,
  output logic [DATA_W-1:0]     src_data,
  output logic [CHANNEL_W-1:0]  src_channel,
  output logic [ERROR_W-1:0]    src_error,
  output logic                  src_startofpacket,
  output logic                  src_endofpacket,
  output logic [EMPTY_W-1:0]    src_empty,
  output logic [PTR_W:0]        fill_level,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int ENTRY_W = DATA_W + CHANNEL_W + ERROR_W + 2 + EMPTY_W;
  localparam logic [PTR_W:0] DEPTH_P = (PTR_W + 1)'(DEPTH);

  ingress_state_t        state_reg, state_next;
  logic [PTR_W:0]        wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]        commit_ptr_reg, commit_ptr_next;
  logic [PTR_W:0]        rd_ptr_reg, wr_base;
  logic [DROP_CNT_W-1:0] drop_count_reg;
  logic                  drop_inc, full, accept, ram_we, ram_re, out_load;
  logic                  ram_valid_reg, out_valid_reg;
  logic [ENTRY_W-1:0]    wr_entry, rd_entry, out_entry_reg;

  assign full      = (wr_ptr_reg - rd_ptr_reg) == DEPTH_P;
  assign snk_ready = resetn && ((state_reg == DROP) || !full);
  assign accept    = snk_valid && snk_ready;
  assign wr_entry  = {snk_data, snk_channel, snk_error,
                      snk_startofpacket, snk_endofpacket, snk_empty};

  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    commit_ptr_next = commit_ptr_reg;
    drop_inc        = 1'b0;
    ram_we          = 1'b0;
    wr_base         = wr_ptr_reg;
    if (!STORE_FWD) begin
      if (accept) begin
        ram_we          = 1'b1;
        wr_ptr_next     = wr_ptr_reg + 1'b1;
        commit_ptr_next = wr_ptr_reg + 1'b1;
        state_next      = snk_endofpacket ? IDLE : PKT;
      end
    end else if (accept && (snk_startofpacket || state_reg == PKT)) begin
      // An SOP always restarts at the commit point, discarding any open packet.
      wr_base  = snk_startofpacket ? commit_ptr_reg : wr_ptr_reg;
      ram_we   = 1'b1;
      drop_inc = snk_startofpacket && (state_reg == PKT);
      if (!snk_endofpacket) begin
        wr_ptr_next = wr_base + 1'b1;
        state_next  = PKT;
      end else if (DROP_ON_ERROR && (snk_error != '0)) begin
        wr_ptr_next = commit_ptr_reg;
        drop_inc    = 1'b1;
        state_next  = IDLE;
      end else begin
        wr_ptr_next     = wr_base + 1'b1;
        commit_ptr_next = wr_base + 1'b1;
        state_next      = IDLE;
      end
    end else if (accept) begin
      if (state_reg == DROP && snk_endofpacket) state_next = IDLE;
    end else if (state_reg == PKT && full && (commit_ptr_reg == rd_ptr_reg)) begin
      // Open packet fills the whole RAM and nothing else can drain: give up on it.
      wr_ptr_next = commit_ptr_reg;
      drop_inc    = 1'b1;
      state_next  = DROP;
    end
  end

  // Two-stage prefetch: RAM read register, then the held output register.
  assign out_load = ram_valid_reg && (!out_valid_reg || src_ready);
  assign ram_re   = (rd_ptr_reg != commit_ptr_reg) && (!ram_valid_reg || out_load);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      rd_ptr_reg     <= '0;
      ram_valid_reg  <= 1'b0;
      out_valid_reg  <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      commit_ptr_reg <= commit_ptr_next;
      if (ram_re) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (ram_re) ram_valid_reg <= 1'b1;
      else if (out_load) ram_valid_reg <= 1'b0;
      if (out_load) out_valid_reg <= 1'b1;
      else if (src_ready) out_valid_reg <= 1'b0;
      if (drop_inc && (drop_count_reg != '1)) drop_count_reg <= drop_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (out_load) out_entry_reg <= rd_entry;
  end

  avalon_st_sdp_ram #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_base[PTR_W-1:0]),
    .wdata(wr_entry),
    .re   (ram_re),
    .raddr(rd_ptr_reg[PTR_W-1:0]),
    .rdata(rd_entry)
  );

  assign src_valid = out_valid_reg;
  assign {src_data, src_channel, src_error,
          src_startofpacket, src_endofpacket, src_empty} = out_entry_reg;
  assign fill_level = wr_ptr_reg - rd_ptr_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_avalon_st_pkt_fifo.sv
// Bench for avalon_st_pkt_fifo: instance 0 is cut-through, instance 1 store-and-forward.
module tb_avalon_st_pkt_fifo;
  import avalon_st_pkg::*;

  localparam int DW = 32, CW = 2, EW = 1, EMW = 2, DEPTH = 8, PW = 3;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [CW-1:0]  ch;
    logic [EW-1:0]  err;
    logic           sop;
    logic           eop;
    logic [EMW-1:0] emp;
  } beat_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          i_valid, i_sop, i_eop, s_ready, o_valid, o_sop, o_eop, src_rdy;
  logic [1:0][DW-1:0]  i_data, o_data;
  logic [1:0][CW-1:0]  i_ch, o_ch;
  logic [1:0][EW-1:0]  i_err, o_err;
  logic [1:0][EMW-1:0] i_emp, o_emp;
  logic [1:0][PW:0]    fill;
  logic [1:0][15:0]    drops;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    avalon_st_pkt_fifo #(
      .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(4), .CHANNEL_W(CW), .ERROR_W(EW),
      .DEPTH(DEPTH), .STORE_FWD(gi == 1), .DROP_ON_ERROR(1'b1)
    ) u_dut (
      .clk(clk), .resetn(resetn),
      .snk_valid(i_valid[gi]), .snk_ready(s_ready[gi]), .snk_data(i_data[gi]),
      .snk_channel(i_ch[gi]), .snk_error(i_err[gi]),
      .snk_startofpacket(i_sop[gi]), .snk_endofpacket(i_eop[gi]), .snk_empty(i_emp[gi]),
      .src_valid(o_valid[gi]), .src_ready(src_rdy[gi]), .src_data(o_data[gi]),
      .src_channel(o_ch[gi]), .src_error(o_err[gi]),
      .src_startofpacket(o_sop[gi]), .src_endofpacket(o_eop[gi]), .src_empty(o_emp[gi]),
      .fill_level(fill[gi]), .drop_count(drops[gi])
    );
  end

  int checks = 0, errors = 0;
  int max_wait = 0;
  bit toggle_en = 1'b0;

  // Packet-level reference: cut-through forwards every beat, store-and-forward
  // forwards only complete, clean, fitting packets that start with SOP.
  beat_t exp_q0[$], exp_q1[$], cur[$];
  bit    in_pkt = 1'b0;
  int    model_drops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [DW-1:0] d, input logic s, input logic e,
                               input logic [EW-1:0] er = '0, input logic [EMW-1:0] em = '0);
    beat_t b;
    b.data = d; b.ch = 2'd1; b.err = er; b.sop = s; b.eop = e; b.emp = em;
    return b;
  endfunction

  function automatic beat_t out_beat(input int k);
    beat_t b;
    b.data = o_data[k]; b.ch = o_ch[k]; b.err = o_err[k];
    b.sop = o_sop[k]; b.eop = o_eop[k]; b.emp = o_emp[k];
    return b;
  endfunction

  task automatic model_accept(input int k, input beat_t b);
    if (k == 0) begin
      exp_q0.push_back(b);
      return;
    end
    if (b.sop) begin
      if (in_pkt) model_drops++;
      cur.delete();
      in_pkt = 1'b1;
    end else if (!in_pkt) begin
      return;
    end else if (cur.size() == DEPTH) begin
      model_drops++;
      cur.delete();
      in_pkt = 1'b0;
      return;
    end
    cur.push_back(b);
    if (b.eop) begin
      if (b.err != '0) model_drops++;
      else foreach (cur[i]) exp_q1.push_back(cur[i]);
      cur.delete();
      in_pkt = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q0.delete(); exp_q1.delete(); cur.delete();
    in_pkt = 1'b0; model_drops = 0;
  endtask

  // Called just after a falling edge; returns just after the falling edge that
  // follows the accepting rising edge.
  task automatic send(input int k, input beat_t b);
    int waits;
    waits = 0;
    i_valid[k] = 1'b1; i_data[k] = b.data; i_ch[k] = b.ch; i_err[k] = b.err;
    i_sop[k] = b.sop; i_eop[k] = b.eop; i_emp[k] = b.emp;
    while (!s_ready[k]) begin
      if (waits == 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: inst %0d snk_ready low %0d cycles, required 1", k, waits);
        i_valid[k] = 1'b0;
        return;
      end
      @(negedge clk);
      waits++;
    end
    if (waits > max_wait) max_wait = waits;
    @(posedge clk);
    model_accept(k, b);
    $display("inst %0d accepted data=%08h sop=%0b eop=%0b err=%0d", k, b.data, b.sop, b.eop, b.err);
    @(negedge clk);
    i_valid[k] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("drain_pending", exp_q0.size() + exp_q1.size(), 0);
  endtask

  // Per-cycle output checker: hold-while-stalled and in-order beat contents.
  initial begin
    beat_t prev [2];
    bit    stall [2];
    beat_t ob, eb;
    stall[0] = 1'b0; stall[1] = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (!resetn) begin
          stall[k] = 1'b0;
          continue;
        end
        ob = out_beat(k);
        if (stall[k]) begin
          check("hold_valid", o_valid[k], 1'b1);
          check("hold_beat", ob, prev[k]);
        end
        if (o_valid[k] && src_rdy[k]) begin
          if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: inst %0d got data=%08h, required no beat", k, ob.data);
          end else begin
            eb = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            $display("inst %0d output data=%08h sop=%0b eop=%0b", k, ob.data, ob.sop, ob.eop);
            check(k == 0 ? "beat_ct" : "beat_sf", ob, eb);
          end
        end
        stall[k] = o_valid[k] && !src_rdy[k];
        prev[k]  = ob;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (toggle_en) src_rdy[1] = ~src_rdy[1];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_valid = '0; i_sop = '0; i_eop = '0; i_data = '0; i_ch = '0; i_err = '0; i_emp = '0;
    src_rdy = 2'b11;
    repeat (3) @(negedge clk);
    check("rst_src_valid", o_valid, 2'b00);
    check("rst_snk_ready", s_ready, 2'b00);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_snk_ready", s_ready, 2'b11);
    check("post_rst_fill", fill, '0);
    check("post_rst_drops", drops, '0);

    // Cut-through: 3-beat packet visible two edges after the first accept.
    send(0, mk(32'hA0A0A0A0, 1'b1, 1'b0));
    check("ct_lat_0", o_valid[0], 1'b0);
    send(0, mk(32'hB0B0B0B0, 1'b0, 1'b0));
    check("ct_lat_1", o_valid[0], 1'b0);
    send(0, mk(32'hC0C0C0C0, 1'b0, 1'b1, 1'b0, 2'd2));
    check("ct_first_valid", o_valid[0], 1'b1);
    check("ct_first_data", o_data[0], 32'hA0A0A0A0);
    check("ct_first_sop", o_sop[0], 1'b1);
    // Cut-through passes stray and errored beats unchanged.
    send(0, mk(32'h55555555, 1'b0, 1'b0));
    send(0, mk(32'h11111111, 1'b1, 1'b0));
    send(0, mk(32'h22222222, 1'b0, 1'b1, 1'b1, 2'd1));
    drain();
    check("ct_drops", drops[0], 16'd0);

    // Store-and-forward: 5-beat packet released after EOP.
    for (int i = 0; i < 5; i++) begin
      send(1, mk(32'h50 + i, i == 0, i == 4, 1'b0, (i == 4) ? 2'd3 : 2'd0));
      check("sf_not_released", o_valid[1], 1'b0);
    end
    check("sf_fill_peak", fill[1], 4'd5);
    @(negedge clk);
    check("sf_lat_1", o_valid[1], 1'b0);
    @(negedge clk);
    check("sf_first_data", o_data[1], 32'h50);
    for (int i = 0; i < 5; i++) begin
      check("sf_streaming", o_valid[1], 1'b1);
      @(negedge clk);
    end
    drain();
    check("sf_drops_0", drops[1], 16'd0);

    // Errored packet dropped, following clean packet passes.
    for (int i = 0; i < 4; i++) send(1, mk(32'hE0 + i, i == 0, i == 3, (i == 3) ? 1'b1 : 1'b0));
    send(1, mk(32'hF0, 1'b1, 1'b0));
    send(1, mk(32'hF1, 1'b0, 1'b1));
    drain();
    check("err_drops", drops[1], 16'd1);

    // Missing EOP: the first packet is dropped when the second SOP arrives.
    send(1, mk(32'h100, 1'b1, 1'b0));
    send(1, mk(32'h101, 1'b0, 1'b0));
    send(1, mk(32'h200, 1'b1, 1'b0));
    send(1, mk(32'h201, 1'b0, 1'b0));
    send(1, mk(32'h202, 1'b0, 1'b1));
    drain();
    check("noeop_drops", drops[1], 16'd2);

    // Oversize: 12 beats into 8 entries with the output stalled.
    src_rdy[1] = 1'b0;
    max_wait = 0;
    for (int i = 0; i < 12; i++) send(1, mk(32'h300 + i, i == 0, i == 11));
    @(negedge clk);
    check("ovf_ready_gap", max_wait, 1);
    check("ovf_drops", drops[1], 16'd3);
    check("ovf_fill", fill[1], 4'd0);
    check("ovf_no_output", o_valid[1], 1'b0);
    src_rdy[1] = 1'b1;
    for (int i = 0; i < 3; i++) send(1, mk(32'h400 + i, i == 0, i == 2));
    drain();
    check("model_drops", drops[1], model_drops);

    // Stalls with a toggling ready, then reset in the middle of a packet.
    toggle_en = 1'b1;
    for (int i = 0; i < 4; i++) send(1, mk(32'h500 + i, i == 0, i == 3));
    drain();
    send(1, mk(32'h600, 1'b1, 1'b0));
    send(1, mk(32'h601, 1'b0, 1'b0));
    resetn = 1'b0;
    toggle_en = 1'b0;
    src_rdy = 2'b11;
    model_reset();
    @(negedge clk);
    check("mid_rst_src_valid", o_valid[1], 1'b0);
    check("mid_rst_snk_ready", s_ready[1], 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst2_snk_ready", s_ready[1], 1'b1);
    check("rst2_src_valid", o_valid[1], 1'b0);
    check("rst2_fill", fill[1], 4'd0);
    check("rst2_drops", drops[1], 16'd0);
    send(1, mk(32'h602, 1'b0, 1'b0));
    send(1, mk(32'h603, 1'b0, 1'b1));
    send(1, mk(32'h700, 1'b1, 1'b0));
    send(1, mk(32'h701, 1'b0, 1'b1));
    drain();
    check("final_drops", drops[1], model_drops);
    check("final_fill", fill[1], 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
